// File: rtl/minterm_sweep_pkg.sv
// Shared definitions for the minterm sweep controller: sweep FSM states,
// input/vector counts, and a lowest-set-bit helper used by the optional
// mismatch checker (enabled by defining MISMATCH_CHECK_EN).
package minterm_sweep_pkg;

    localparam int N_IN  = 5;
    localparam int N_VEC = 32;
    localparam int ONES_W = 6;
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sweep_state_t;

    // Index of the lowest set bit of v, or 0 when v is all zeros.
    function automatic logic [N_IN-1:0] lowest_set(input logic [N_VEC-1:0] v);
        logic [N_IN-1:0] idx;
        idx = '0;
        for (int i = N_VEC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = N_IN'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/minterm_sweep_ctrl_sop_eval.sv
// Five-input combinational function under test: F = (A|B)&(C|D)&E.
module sop_eval (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    input  logic e,
    output logic f
);

    assign f = (a | b) & (c | d) & e;

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Minterm sweep controller: on start, walks vec through all 32 input
// vectors, holds each for 1+HOLD_CYCLES cycles, and captures the evaluator
// output into a truth table plus a minterm count. done pulses for one cycle
// at the end of the sweep; results hold in IDLE until the next start.
// Optional feature macro: MISMATCH_CHECK_EN adds the expected input and the
// mismatch/first_bad outputs, registered in the DONE cycle.
module minterm_sweep_ctrl
    import minterm_sweep_pkg::*;
#(
    parameter int HOLD_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [N_IN-1:0]   vec,
    output logic [N_VEC-1:0]  tt,
    output logic [ONES_W-1:0] ones
`ifdef MISMATCH_CHECK_EN
    ,
    input  logic [N_VEC-1:0]  expected,
    output logic              mismatch,
    output logic [N_IN-1:0]   first_bad
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES);
    localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(N_VEC - 1);
    localparam logic [N_IN-1:0]   VEC_ONE   = N_IN'(1);

    sweep_state_t      state_reg, state_next;
    logic [N_IN-1:0]   vec_reg, vec_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
    logic [N_VEC-1:0]  tt_reg, tt_next;
    logic [ONES_W-1:0] ones_reg, ones_next;
    logic [N_VEC-1:0]  hit;
    logic              sample;
    logic              clear_results;
    logic              f_val;

    sop_eval u_eval (
        .a (vec_reg[4]),
        .b (vec_reg[3]),
        .c (vec_reg[2]),
        .d (vec_reg[1]),
        .e (vec_reg[0]),
        .f (f_val)
    );

    // The last hold cycle of the current vector is the one that captures F.
    assign sample = (state_reg == RUN) && (hold_cnt_reg == HOLD_LAST);

    // Next-state, vector stepping and hold counting for the sweep FSM.
    always_comb begin
        state_next    = state_reg;
        vec_next      = vec_reg;
        hold_cnt_next = hold_cnt_reg;
        clear_results = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next    = RUN;
                    vec_next      = '0;
                    hold_cnt_next = '0;
                    clear_results = 1'b1;
                end
            end
            RUN: begin
                if (sample) begin
                    hold_cnt_next = '0;
                    // vec parks at the last vector rather than wrapping.
                    if (vec_reg == VEC_LAST) begin
                        state_next = DONE;
                    end else begin
                        vec_next = vec_reg + VEC_ONE;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Per-bit truth-table update: clear on start, write F at the sampled index.
    for (genvar gi = 0; gi < N_VEC; gi++) begin : g_tt
        assign hit[gi]     = sample && (vec_reg == N_IN'(gi));
        assign tt_next[gi] = clear_results ? 1'b0 :
                             (hit[gi] ? f_val : tt_reg[gi]);
    end

    // Minterm count: cleared on start, bumped on each sampled F=1.
    always_comb begin
        ones_next = ones_reg;
        if (clear_results) begin
            ones_next = '0;
        end else if (sample && f_val) begin
            ones_next = ones_reg + ONES_W'(1);
        end
    end

    // Sweep state registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            vec_reg      <= '0;
            hold_cnt_reg <= '0;
            tt_reg       <= '0;
            ones_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            vec_reg      <= vec_next;
            hold_cnt_reg <= hold_cnt_next;
            tt_reg       <= tt_next;
            ones_reg     <= ones_next;
        end
    end

    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign vec  = vec_reg;
    assign tt   = tt_reg;
    assign ones = ones_reg;

`ifdef MISMATCH_CHECK_EN
    logic              mismatch_reg, mismatch_next;
    logic [N_IN-1:0]   first_bad_reg, first_bad_next;
    logic [N_VEC-1:0]  diff;

    // In DONE, tt_reg already holds the final sample, so compare directly.
    assign diff = tt_reg ^ expected;

    // Capture the comparison in DONE; clear alongside the results on start.
    always_comb begin
        mismatch_next  = mismatch_reg;
        first_bad_next = first_bad_reg;
        if (clear_results) begin
            mismatch_next  = 1'b0;
            first_bad_next = '0;
        end else if (state_reg == DONE) begin
            mismatch_next  = |diff;
            first_bad_next = lowest_set(diff);
        end
    end

    // Mismatch result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_reg  <= 1'b0;
            first_bad_reg <= '0;
        end else begin
            mismatch_reg  <= mismatch_next;
            first_bad_reg <= first_bad_next;
        end
    end

    assign mismatch  = mismatch_reg;
    assign first_bad = first_bad_reg;
`endif

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Self-checking bench for minterm_sweep_ctrl. Two instances run side by side:
// dut0 with HOLD_CYCLES=0 and dut2 with HOLD_CYCLES=2; 'cur' selects which
// one the stimulus tasks drive and observe. The reference truth table is
// built from the boolean formula over integer bit positions.
module tb_minterm_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst     = 1'b1;
    logic start_c = 1'b0;
    int   cur     = 0;

    logic        start0, start2;
    logic        busy0, done0, busy2, done2;
    logic [4:0]  vec0, vec2;
    logic [31:0] tt0, tt2;
    logic [5:0]  ones0, ones2;

    logic        m_busy, m_done;
    logic [4:0]  m_vec;
    logic [31:0] m_tt;
    logic [5:0]  m_ones;

    assign start0 = start_c && (cur == 0);
    assign start2 = start_c && (cur == 2);
    assign m_busy = (cur == 2) ? busy2 : busy0;
    assign m_done = (cur == 2) ? done2 : done0;
    assign m_vec  = (cur == 2) ? vec2  : vec0;
    assign m_tt   = (cur == 2) ? tt2   : tt0;
    assign m_ones = (cur == 2) ? ones2 : ones0;

`ifdef MISMATCH_CHECK_EN
    logic [31:0] expected_c = 32'h0;
    logic        mm0, mm2, m_mm;
    logic [4:0]  fb0, fb2, m_fb;
    assign m_mm = (cur == 2) ? mm2 : mm0;
    assign m_fb = (cur == 2) ? fb2 : fb0;
`endif

    minterm_sweep_ctrl #(.HOLD_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst   (rst),
        .start (start0),
        .busy  (busy0),
        .done  (done0),
        .vec   (vec0),
        .tt    (tt0),
        .ones  (ones0)
`ifdef MISMATCH_CHECK_EN
        ,
        .expected  (expected_c),
        .mismatch  (mm0),
        .first_bad (fb0)
`endif
    );

    minterm_sweep_ctrl #(.HOLD_CYCLES(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .busy  (busy2),
        .done  (done2),
        .vec   (vec2),
        .tt    (tt2),
        .ones  (ones2)
`ifdef MISMATCH_CHECK_EN
        ,
        .expected  (expected_c),
        .mismatch  (mm2),
        .first_bad (fb2)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] last_tt   [0:2];
    logic [5:0]  last_ones [0:2];
    logic [4:0]  last_vec  [0:2];

    // Truth table straight from F = (A|B)&(C|D)&E with A the MSB of the index.
    function automatic logic [31:0] ref_tt();
        logic [31:0] t;
        int a, b, c, d, e;
        t = 32'h0;
        for (int i = 0; i < 32; i++) begin
            a = (i / 16) % 2;
            b = (i / 8) % 2;
            c = (i / 4) % 2;
            d = (i / 2) % 2;
            e = i % 2;
            t[i] = ((a + b) > 0) && ((c + d) > 0) && (e == 1);
        end
        return t;
    endfunction

    function automatic int ref_ones(input logic [31:0] t);
        int n;
        n = 0;
        for (int i = 0; i < 32; i++) n += int'(t[i]);
        return n;
    endfunction

    function automatic int ref_first_bad(input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < 32; i++) begin
            if (x[i] != y[i]) return i;
        end
        return 0;
    endfunction

    task automatic kick();
        @(negedge clk);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
    endtask

    task automatic mark_reset();
        for (int i = 0; i < 3; i++) begin
            last_tt[i]   = 32'h0;
            last_ones[i] = 6'd0;
            last_vec[i]  = 5'd0;
        end
    endtask

    // Called at the negedge right after start was accepted; follows the sweep
    // to done and checks vector pacing, latency, results and the IDLE hold.
    task automatic run_and_check(input int h, input int poke_vec, input string tag);
        int k;
        int vexp;
        bit seen_done;
        bit poked;
        logic [31:0] want_tt;
        int want_ones;
        seen_done = 0;
        poked     = 0;
        want_tt   = ref_tt();
        want_ones = ref_ones(want_tt);

        checks++;
        if (m_busy !== 1'b1 || m_vec !== 5'd0 || m_tt !== 32'h0 || m_ones !== 6'd0) begin
            errors++;
            $display("FAIL %s start_state: busy=%b vec=%0d tt=%h ones=%0d, want busy=1 vec=0 tt=0 ones=0",
                     tag, m_busy, m_vec, m_tt, m_ones);
        end

        for (k = 1; k <= 32 * (h + 1) + 8; k++) begin
            @(negedge clk);
            start_c = 1'b0;
            if (m_done === 1'b1) begin
                seen_done = 1;
                break;
            end
            vexp = k / (h + 1);
            checks++;
            if (m_busy !== 1'b1 || m_vec !== vexp[4:0]) begin
                errors++;
                $display("FAIL %s run_vec at cycle %0d: busy=%b vec=%0d, want busy=1 vec=%0d",
                         tag, k, m_busy, m_vec, vexp);
            end
            if (!poked && poke_vec >= 0 && m_vec === poke_vec[4:0]) begin
                start_c = 1'b1;
                poked   = 1;
            end
        end

        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", tag, 32 * (h + 1) + 8);
            return;
        end

        checks++;
        if (k != 32 * (h + 1) || m_vec !== 5'd31 || m_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_latency: cycles=%0d vec=%0d busy=%b, want cycles=%0d vec=31 busy=0",
                     tag, k, m_vec, m_busy, 32 * (h + 1));
        end

        checks++;
        if (m_tt !== want_tt || m_ones !== want_ones[5:0]) begin
            errors++;
            $display("FAIL %s result: tt=%h ones=%0d, want tt=%h ones=%0d",
                     tag, m_tt, m_ones, want_tt, want_ones);
        end

        @(negedge clk);
        checks++;
        if (m_done !== 1'b0 || m_busy !== 1'b0 || m_tt !== want_tt ||
            m_ones !== want_ones[5:0] || m_vec !== 5'd31) begin
            errors++;
            $display("FAIL %s idle_after_done: done=%b busy=%b tt=%h ones=%0d vec=%0d, want done=0 busy=0 tt=%h ones=%0d vec=31",
                     tag, m_done, m_busy, m_tt, m_ones, m_vec, want_tt, want_ones);
        end

`ifdef MISMATCH_CHECK_EN
        begin
            logic want_mm;
            int   want_fb;
            want_mm = (want_tt != expected_c);
            want_fb = ref_first_bad(want_tt, expected_c);
            checks++;
            if (m_mm !== want_mm || m_fb !== want_fb[4:0]) begin
                errors++;
                $display("FAIL %s mismatch: mismatch=%b first_bad=%0d, want mismatch=%b first_bad=%0d (expected=%h)",
                         tag, m_mm, m_fb, want_mm, want_fb, expected_c);
            end
        end
`endif

        last_tt[cur]   = want_tt;
        last_ones[cur] = want_ones[5:0];
        last_vec[cur]  = 5'd31;
        $display("sweep %s: hold=%0d cycles=%0d tt=%h ones=%0d", tag, h, k, m_tt, m_ones);
    endtask

    // Waits (bounded) until vec reaches target during RUN, then asserts reset
    // for one edge and checks that every output returns to its reset value.
    task automatic reset_at_vec(input int target, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_vec === target[4:0] && m_busy === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s vec_wait: vec=%0d never reached, last vec=%0d", tag, target, m_vec);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0 || m_vec !== 5'd0 ||
            m_tt !== 32'h0 || m_ones !== 6'd0) begin
            errors++;
            $display("FAIL %s reset_values: busy=%b done=%b vec=%0d tt=%h ones=%0d, want all 0",
                     tag, m_busy, m_done, m_vec, m_tt, m_ones);
        end
`ifdef MISMATCH_CHECK_EN
        checks++;
        if (m_mm !== 1'b0 || m_fb !== 5'd0) begin
            errors++;
            $display("FAIL %s reset_mismatch: mismatch=%b first_bad=%0d, want 0 0", tag, m_mm, m_fb);
        end
`endif
        mark_reset();
        $display("reset %s at vec=%0d", tag, target);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start_c = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s <= 2; s += 2) begin
            cur = s;
            #1;
            checks++;
            if (m_busy !== 1'b0 || m_done !== 1'b0 || m_vec !== 5'd0 ||
                m_tt !== 32'h0 || m_ones !== 6'd0) begin
                errors++;
                $display("FAIL reset dut%0d: busy=%b done=%b vec=%0d tt=%h ones=%0d, want all 0",
                         s, m_busy, m_done, m_vec, m_tt, m_ones);
            end
`ifdef MISMATCH_CHECK_EN
            checks++;
            if (m_mm !== 1'b0 || m_fb !== 5'd0) begin
                errors++;
                $display("FAIL reset_mismatch dut%0d: mismatch=%b first_bad=%0d, want 0 0", s, m_mm, m_fb);
            end
`endif
        end
        cur = 0;
        mark_reset();
        $display("reset: both instances checked");
    endtask

    task automatic test_full_sweep();
        cur = 0;
        kick();
        run_and_check(0, -1, "full_sweep");
    endtask

    task automatic test_hold_timing();
        cur = 2;
        kick();
        run_and_check(2, -1, "hold_timing");
        cur = 0;
    endtask

    task automatic test_start_while_busy();
        cur = 0;
        kick();
        run_and_check(0, 5, "start_while_busy");
    endtask

    task automatic test_reset_mid_run();
        cur = 0;
        kick();
        reset_at_vec(10, "mid_run");
        kick();
        run_and_check(0, -1, "after_reset");
    endtask

    // start held high through the whole sweep: the sweep ends normally,
    // IDLE lasts one cycle, and a fresh sweep begins right after it.
    task automatic test_back_to_back();
        bit seen;
        cur = 0;
        seen = 0;
        @(negedge clk);
        start_c = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (m_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        checks++;
        if (!seen || m_tt !== ref_tt()) begin
            errors++;
            $display("FAIL b2b first_sweep: done_seen=%0d tt=%h, want 1 %h", seen, m_tt, ref_tt());
        end
        @(negedge clk);
        checks++;
        if (m_busy !== 1'b0 || m_done !== 1'b0 || m_tt !== ref_tt()) begin
            errors++;
            $display("FAIL b2b idle_gap: busy=%b done=%b tt=%h, want busy=0 done=0 tt=%h",
                     m_busy, m_done, m_tt, ref_tt());
        end
        @(negedge clk);
        start_c = 1'b0;
        run_and_check(0, -1, "back_to_back");
    endtask

`ifdef MISMATCH_CHECK_EN
    task automatic test_mismatch();
        cur = 0;
        expected_c = 32'hA8A8A801;
        kick();
        run_and_check(0, -1, "mismatch_bit0");
        expected_c = 32'hA8A8A800;
        kick();
        run_and_check(0, -1, "mismatch_none");
    endtask
`endif

    task automatic test_random();
        int gap;
        int poke;
        for (int it = 0; it < 8; it++) begin
            cur = 2 * int'($urandom_range(0, 1));
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++;
                if (m_busy !== 1'b0 || m_tt !== last_tt[cur] ||
                    m_ones !== last_ones[cur] || m_vec !== last_vec[cur]) begin
                    errors++;
                    $display("FAIL random idle_hold dut%0d: busy=%b tt=%h ones=%0d vec=%0d, want busy=0 tt=%h ones=%0d vec=%0d",
                             cur, m_busy, m_tt, m_ones, m_vec, last_tt[cur], last_ones[cur], last_vec[cur]);
                end
            end
`ifdef MISMATCH_CHECK_EN
            if ($urandom_range(0, 1) == 0) expected_c = ref_tt();
            else expected_c = ref_tt() ^ (32'h1 << $urandom_range(0, 31));
`endif
            if ($urandom_range(0, 2) == 0) begin
                kick();
                reset_at_vec(int'($urandom_range(0, 31)), "random");
            end
            poke = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 31));
            kick();
            run_and_check(cur, poke, "random");
        end
        cur = 0;
    endtask

    initial begin
        mark_reset();
        test_reset();
        test_full_sweep();
        test_hold_timing();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MISMATCH_CHECK_EN
        test_mismatch();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/minterm_sweep_ctrl.md
MINTERM_SWEEP_CTRL -- requirements
Module: minterm_sweep_ctrl

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Parameter: HOLD_CYCLES, default 0, extra settle cycles each input vector is held before sampling (legal 0..15).
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: start  input  1  request a full 32-vector sweep; sampled only in IDLE.
REQ-006 Port: busy  output  1  high while in RUN.
REQ-007 Port: done  output  1  one-cycle pulse when a sweep completes.
REQ-008 Port: vec  output  5  vector currently applied to the evaluator; mapping {A,B,C,D,E} = vec[4:0].
REQ-009 Port: tt  output  32  captured truth table; tt[i] = F at vec = i.
REQ-010 Port: ones  output  6  count of minterms (F=1), range 0..32.
REQ-011 Port (MISMATCH_CHECK_EN only): expected  input  32  reference truth table, sampled at the DONE cycle.
REQ-012 Port (MISMATCH_CHECK_EN only): mismatch  output  1  tt != expected after the last sweep.
REQ-013 Port (MISMATCH_CHECK_EN only): first_bad  output  5  lowest index where tt and expected differ, 0 if none.

Function
REQ-014 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-015 IDLE SHALL move to RUN when start=1; the same edge clears tt and ones, sets vec=0, and clears the hold counter.
REQ-016 In RUN, each vec SHALL be held for 1+HOLD_CYCLES cycles; on the last cycle F is written into tt[vec] and ones increments if F=1.
REQ-017 After sampling, vec SHALL increment; after sampling vec=31, the FSM SHALL enter DONE and vec SHALL hold at 31, with no wrap to 0 inside a sweep.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 Latency: with start accepted at edge N, done SHALL be high in cycle N+1+32*(1+HOLD_CYCLES).
REQ-020 start SHALL be ignored in RUN and DONE; a start held high through DONE SHALL begin a new sweep from IDLE on the next cycle.
REQ-021 tt, ones, vec (and the mismatch outputs) SHALL hold stable in IDLE until the next accepted start.
REQ-022 ones SHALL be 6 bits wide so that an all-ones function reports 32 without overflow.
REQ-023 F SHALL come combinationally from the evaluator sub-module: F = (A|B)&(C|D)&E.

Reset
REQ-024 When rst=1 at any edge, including mid-sweep, the FSM SHALL go to IDLE, set busy=0, done=0, vec=0, tt=0 and ones=0, and clear the hold counter.
REQ-025 Under MISMATCH_CHECK_EN, reset SHALL also set mismatch=0 and first_bad=0.
REQ-026 rst SHALL take priority over start on the same edge.

Configuration
REQ-027 The macro MISMATCH_CHECK_EN SHALL control the mismatch-check feature.
REQ-028 With MISMATCH_CHECK_EN defined, mismatch and first_bad SHALL be registered in the DONE cycle from the final tt (including the last sample) against expected, and held until the next start or reset.
REQ-029 Without MISMATCH_CHECK_EN, the expected, mismatch and first_bad ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The shared package minterm_sweep_pkg SHALL hold the state enum (IDLE, RUN, DONE), N_IN=5 and N_VEC=32.
REQ-031 The sub-module sop_eval SHALL implement the five-input combinational function (inputs A..E, output F) and SHALL be instantiated once.
REQ-032 No other sub-modules SHALL be used.

Verification
REQ-033 Reset check: assert rst for 2 cycles -> busy=0, done=0, vec=0, tt=0x00000000, ones=0.
REQ-034 Full sweep: HOLD_CYCLES=0, start pulsed at edge N -> done high exactly at cycle N+33, tt=0xA8A8A800, ones=9.
REQ-035 Hold timing: HOLD_CYCLES=2 -> done at cycle N+97, with each vec value stable for 3 cycles; tt and ones are the same as in REQ-034.
REQ-036 Start while busy: pulse start at vec=5 during RUN -> no restart; done fires at the original cycle; results are unchanged.
REQ-037 Reset mid-run: assert rst when vec=10 -> all outputs return to reset values the next cycle; a new start then gives tt=0xA8A8A800.
REQ-038 Mismatch check (MISMATCH_CHECK_EN): expected=0xA8A8A801 -> mismatch=1, first_bad=0; expected=0xA8A8A800 -> mismatch=0, first_bad=0.
